// File: rtl/vrf_read_scheduler.sv
// Shares one VRF read port among NREQ credit-limited requesters with round-robin
// arbitration, and routes each fixed-latency read result back to its requester.
module vrf_read_scheduler #(
    parameter int NREQ         = 4,
    parameter int CREDITS      = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [5*NREQ-1:0]       req_vs,
    input  logic [9*NREQ-1:0]       req_offset,
    input  logic [3*NREQ-1:0]       req_instructionIndex,
    output logic                    vrfReadRequest_valid,
    input  logic                    vrfReadRequest_ready,
    output logic [4:0]              vrfReadRequest_bits_vs,
    output logic [8:0]              vrfReadRequest_bits_offset,
    output logic [$clog2(NREQ)-1:0] vrfReadRequest_bits_readSource,
    output logic [2:0]              vrfReadRequest_bits_instructionIndex,
    input  logic [31:0]             vrfReadResult,
    output logic [NREQ-1:0]         resp_valid,
    output logic [31:0]             resp_bits,
    input  logic [NREQ-1:0]         credit_return,
    output logic                    credit_error,
    output logic                    idle
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(CREDITS + 1);

    logic [IW-1:0]   ptr;
    logic [CW-1:0]   credit [NREQ];
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] credit_full;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   search_idx;
    logic            any_eligible;
    logic            fire;
    logic            overflow;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [IW-1:0]           pipe_idx [READ_LATENCY];

    always_comb begin
        eligible    = '0;
        credit_full = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i]    = req_valid[i] && (credit[i] != '0);
            credit_full[i] = (credit[i] == CW'(CREDITS));
        end
    end

    // Search ascends from ptr; the index wraps naturally because NREQ is a power of two.
    always_comb begin
        winner       = '0;
        search_idx   = '0;
        any_eligible = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            search_idx = ptr + IW'(k);
            if (!any_eligible && eligible[search_idx]) begin
                winner       = search_idx;
                any_eligible = 1'b1;
            end
        end
    end

    assign fire                                 = any_eligible && vrfReadRequest_ready;
    assign vrfReadRequest_valid                 = any_eligible;
    assign vrfReadRequest_bits_vs               = req_vs[5*int'(winner) +: 5];
    assign vrfReadRequest_bits_offset           = req_offset[9*int'(winner) +: 9];
    assign vrfReadRequest_bits_instructionIndex = req_instructionIndex[3*int'(winner) +: 3];
    assign vrfReadRequest_bits_readSource       = winner;
    assign req_ready                            = fire ? (NREQ'(1) << winner) : '0;

    // A return that coincides with that requester's own fire cancels out, so it can never overflow.
    assign overflow = |(credit_return & credit_full & ~req_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (fire) begin
            ptr <= winner + IW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                credit[i] <= CW'(CREDITS);
            end
            credit_error <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (credit_return[i] && !req_ready[i] && !credit_full[i]) begin
                    credit[i] <= credit[i] + CW'(1);
                end else if (req_ready[i] && !credit_return[i]) begin
                    credit[i] <= credit[i] - CW'(1);
                end
            end
            if (overflow) begin
                credit_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= fire;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        pipe_idx[0] <= winner;
        for (int s = 1; s < READ_LATENCY; s++) begin
            pipe_idx[s] <= pipe_idx[s-1];
        end
    end

    // Masking with reset keeps a read caught by reset from being delivered in the reset cycle itself.
    assign resp_valid = (pipe_valid[READ_LATENCY-1] && !reset) ?
                        (NREQ'(1) << pipe_idx[READ_LATENCY-1]) : '0;
    assign resp_bits  = vrfReadResult;
    assign idle       = ~|pipe_valid;

endmodule

// File: tb/tb_vrf_read_scheduler.sv
// Self-checking bench for vrf_read_scheduler: directed scenarios plus random traffic,
// all compared cycle by cycle against a credit/queue reference model.
module tb_vrf_read_scheduler;

    localparam int N  = 4;
    localparam int CR = 4;
    localparam int L  = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [5*N-1:0] req_vs;
    logic [9*N-1:0] req_offset;
    logic [3*N-1:0] req_ii;
    logic          vrf_valid;
    logic          vrf_ready;
    logic [4:0]    vs_o;
    logic [8:0]    off_o;
    logic [1:0]    src_o;
    logic [2:0]    ii_o;
    logic [31:0]   result;
    logic [N-1:0]  resp_valid;
    logic [31:0]   resp_bits;
    logic [N-1:0]  credit_return;
    logic          credit_error;
    logic          idle;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mcred [N];
    int mptr;
    bit merr;
    int due_q [$];
    int idx_q [$];
    int cyc = 0;

    // Values observed at the last sample point, for directed checks
    logic [1:0]   last_src;
    logic [N-1:0] last_ready;
    logic         last_valid;
    logic [N-1:0] last_resp;
    logic [31:0]  last_bits;
    logic         last_idle;
    logic         last_err;

    vrf_read_scheduler #(.NREQ(N), .CREDITS(CR), .READ_LATENCY(L)) dut (
        .clock                               (clock),
        .reset                               (reset),
        .req_valid                           (req_valid),
        .req_ready                           (req_ready),
        .req_vs                              (req_vs),
        .req_offset                          (req_offset),
        .req_instructionIndex                (req_ii),
        .vrfReadRequest_valid                (vrf_valid),
        .vrfReadRequest_ready                (vrf_ready),
        .vrfReadRequest_bits_vs              (vs_o),
        .vrfReadRequest_bits_offset          (off_o),
        .vrfReadRequest_bits_readSource      (src_o),
        .vrfReadRequest_bits_instructionIndex(ii_o),
        .vrfReadResult                       (result),
        .resp_valid                          (resp_valid),
        .resp_bits                           (resp_bits),
        .credit_return                       (credit_return),
        .credit_error                        (credit_error),
        .idle                                (idle)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) mcred[i] = CR;
        mptr = 0;
        merr = 1'b0;
        due_q.delete();
        idx_q.delete();
    endtask

    task automatic doReset(input int n);
        reset         = 1'b1;
        req_valid     = '0;
        vrf_ready     = 1'b0;
        credit_return = '0;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    // Drives one cycle of inputs, checks every output against the model at the
    // falling edge, then advances the model as the rising edge will.
    task automatic applyStimulusR(input logic [N-1:0] v, input logic rdy,
                                  input logic [N-1:0] ret, input logic [31:0] res);
        int w;
        int idx;
        bit fired;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_resp;
        logic [4:0] e_vs;
        logic [8:0] e_off;
        logic [2:0] e_ii;
        req_valid     = v;
        vrf_ready     = rdy;
        credit_return = ret;
        result        = res;
        req_vs        = 20'($urandom());
        req_offset    = 36'({$urandom(), $urandom()});
        req_ii        = 12'($urandom());
        @(negedge clock);
        w = -1;
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (w < 0 && v[idx] && mcred[idx] > 0) w = idx;
        end
        exp_ready = '0;
        if (rdy && w >= 0) exp_ready[w] = 1'b1;
        checkOutput("request_valid", 64'(vrf_valid), 64'(w >= 0));
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        if (w >= 0) begin
            e_vs  = req_vs[5*w +: 5];
            e_off = req_offset[9*w +: 9];
            e_ii  = req_ii[3*w +: 3];
            checkOutput("read_source", 64'(src_o), 64'(w));
            checkOutput("bits_vs", 64'(vs_o), 64'(e_vs));
            checkOutput("bits_offset", 64'(off_o), 64'(e_off));
            checkOutput("bits_instr_index", 64'(ii_o), 64'(e_ii));
        end
        exp_resp = '0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_resp[idx_q[0]] = 1'b1;
            checkOutput("resp_bits", 64'(resp_bits), 64'(res));
        end
        checkOutput("resp_valid", 64'(resp_valid), 64'(exp_resp));
        checkOutput("idle", 64'(idle), 64'(due_q.size() == 0));
        checkOutput("credit_error", 64'(credit_error), 64'(merr));
        last_src   = src_o;
        last_ready = req_ready;
        last_valid = vrf_valid;
        last_resp  = resp_valid;
        last_bits  = resp_bits;
        last_idle  = idle;
        last_err   = credit_error;

        fired = rdy && (w >= 0);
        for (int i = 0; i < N; i++) begin
            if (ret[i] && !(fired && w == i)) begin
                if (mcred[i] == CR) merr = 1'b1;
                else mcred[i]++;
            end else if (!ret[i] && fired && w == i) begin
                mcred[i]--;
            end
        end
        if (fired) mptr = (w + 1) % N;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            void'(idx_q.pop_front());
        end
        if (fired) begin
            due_q.push_back(cyc + L);
            idx_q.push_back(w);
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic rdy, input logic [N-1:0] ret);
        applyStimulusR(v, rdy, ret, $urandom());
    endtask

    initial begin
        int cnt;
        int first_fire;
        logic [N-1:0] rv;
        logic [N-1:0] rret;

        doReset(2);
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        checkOutput("reset_idle", 64'(last_idle), 64'(1));
        checkOutput("reset_resp_valid", 64'(last_resp), 64'(0));

        // Round-robin across all four requesters
        doReset(1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 1'b1, 4'b0000);
            checkOutput("rr_source", 64'(last_src), 64'(k % 4));
        end

        // Single fire from requester 2, result returns two cycles later
        doReset(1);
        applyStimulus(4'b0100, 1'b1, 4'b0000);
        checkOutput("lat_fire", 64'(last_ready), 64'(4'b0100));
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        checkOutput("lat_idle_t1", 64'(last_idle), 64'(0));
        checkOutput("lat_no_resp_t1", 64'(last_resp), 64'(0));
        applyStimulusR(4'b0000, 1'b0, 4'b0000, 32'hDEADBEEF);
        checkOutput("lat_resp_valid", 64'(last_resp), 64'(4'b0100));
        checkOutput("lat_resp_bits", 64'(last_bits), 64'(32'hDEADBEEF));
        checkOutput("lat_idle_t2", 64'(last_idle), 64'(0));
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        checkOutput("lat_resp_gone", 64'(last_resp), 64'(0));
        checkOutput("lat_idle_t3", 64'(last_idle), 64'(1));

        // Credit exhaustion on requester 1 and recovery by one return
        doReset(1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0010, 1'b1, 4'b0000);
            cnt += int'(last_ready[1]);
        end
        checkOutput("exhaust_fires", 64'(cnt), 64'(4));
        checkOutput("exhaust_valid", 64'(last_valid), 64'(0));
        applyStimulus(4'b0010, 1'b1, 4'b0010);
        checkOutput("return_cycle_no_fire", 64'(last_ready), 64'(0));
        cnt = 0;
        first_fire = -1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0010, 1'b1, 4'b0000);
            if (last_ready[1] && first_fire < 0) first_fire = k;
            cnt += int'(last_ready[1]);
        end
        checkOutput("refill_fires", 64'(cnt), 64'(1));
        checkOutput("refill_first_cycle", 64'(first_fire), 64'(0));

        // Port stall holds the grant on requester 0
        doReset(1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1001, 1'b0, 4'b0000);
            checkOutput("stall_source", 64'(last_src), 64'(0));
            checkOutput("stall_ready", 64'(last_ready), 64'(0));
            checkOutput("stall_valid", 64'(last_valid), 64'(1));
        end
        applyStimulus(4'b1001, 1'b1, 4'b0000);
        checkOutput("stall_release_0", 64'(last_ready), 64'(4'b0001));
        applyStimulus(4'b1001, 1'b1, 4'b0000);
        checkOutput("stall_release_3", 64'(last_ready), 64'(4'b1000));

        // Simultaneous fire and return at full credit, then an overflowing return
        doReset(1);
        applyStimulus(4'b0001, 1'b1, 4'b0001);
        checkOutput("fr_fire", 64'(last_ready), 64'(4'b0001));
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        checkOutput("fr_no_error", 64'(last_err), 64'(0));
        applyStimulus(4'b0000, 1'b0, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0000, 1'b0, 4'b0000);
            checkOutput("overflow_sticky", 64'(last_err), 64'(1));
        end
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0001, 1'b1, 4'b0000);
            cnt += int'(last_ready[0]);
        end
        checkOutput("overflow_clamped_fires", 64'(cnt), 64'(4));
        checkOutput("overflow_still_set", 64'(last_err), 64'(1));
        doReset(1);
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        checkOutput("overflow_cleared", 64'(last_err), 64'(0));

        // Reset one cycle after a fire discards the read
        doReset(1);
        applyStimulus(4'b0010, 1'b1, 4'b0000);
        checkOutput("midflight_fire", 64'(last_ready), 64'(4'b0010));
        doReset(1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0000, 1'b0, 4'b0000);
            checkOutput("midflight_no_resp", 64'(last_resp), 64'(0));
            checkOutput("midflight_idle", 64'(last_idle), 64'(1));
        end
        applyStimulus(4'b1111, 1'b0, 4'b0000);
        checkOutput("midflight_ptr", 64'(last_src), 64'(0));
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0010, 1'b1, 4'b0000);
            cnt += int'(last_ready[1]);
        end
        checkOutput("midflight_credits", 64'(cnt), 64'(4));

        // Random traffic with mostly legal credit returns
        for (int seg = 0; seg < 2; seg++) begin
            doReset(1);
            for (int k = 0; k < 400; k++) begin
                rv = N'($urandom());
                rret = '0;
                for (int i = 0; i < N; i++) begin
                    if (mcred[i] < CR && $urandom_range(0, 2) == 0) rret[i] = 1'b1;
                    else if (seg == 1 && $urandom_range(0, 99) == 0) rret[i] = 1'b1;
                end
                applyStimulus(rv, ($urandom_range(0, 3) != 0), rret);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vrf_read_scheduler.md
VRF_READ_SCHEDULER -- requirements
Module: vrf_read_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of read requesters sharing one VRF read port; SHALL be a power of two, 2..8.
REQ-002 Parameter CREDITS, default 4: per-requester result-buffer depth; one credit is one free result slot.
REQ-003 Parameter READ_LATENCY, default 2: cycles from VRF request fire to vrfReadResult valid; SHALL be at least 1.
REQ-004 The block has one clock; reset is synchronous and active-high.
REQ-005 Ports, clock and reset first:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accepted.
- req_vs  in  5*NREQ  packed vector register; requester i occupies bits [5i+4:5i].
- req_offset  in  9*NREQ  packed offset.
- req_instructionIndex  in  3*NREQ  packed instruction index.
- vrfReadRequest_valid  out  1  VRF port request.
- vrfReadRequest_ready  in  1  VRF port accept.
- vrfReadRequest_bits_vs  out  5  granted vs.
- vrfReadRequest_bits_offset  out  9  granted offset.
- vrfReadRequest_bits_readSource  out  log2(NREQ)  granted requester index.
- vrfReadRequest_bits_instructionIndex  out  3  granted instruction index.
- vrfReadResult  in  32  VRF read data, valid READ_LATENCY cycles after fire.
- resp_valid  out  NREQ  one-hot result strobe.
- resp_bits  out  32  result data, broadcast to all requesters.
- credit_return  in  NREQ  a pulse on bit i means requester i freed one result slot.
- credit_error  out  1  sticky credit-protocol violation flag.
- idle  out  1  no reads in flight.

Function
REQ-006 Requester i is eligible iff req_valid[i]=1 and credit[i]!=0.
REQ-007 Winner selection is round-robin over eligible requesters:
- The search starts at pointer ptr and ascends modulo NREQ.
- The first eligible requester found wins.
REQ-008 Request path (combinational from registered state):
- vrfReadRequest_valid=1 iff any requester is eligible.
- All vrfReadRequest_bits_* carry the winner's fields.
- readSource equals the winner index.
REQ-009 req_ready[i] = vrfReadRequest_ready & vrfReadRequest_valid & (winner==i). At most one bit of req_ready is set per cycle.
REQ-010 A fire is vrfReadRequest_valid & vrfReadRequest_ready. On fire, ptr <= (winner+1) mod NREQ. Without a fire, ptr holds its value.
REQ-011 Credit updates:
- On fire, credit[winner] decrements by 1.
- A credit_return[i] pulse increments credit[i] by 1.
- A fire and a return on the same requester in the same cycle leave credit unchanged.
REQ-012 Credit overflow: a return that would take credit[i] above CREDITS SHALL leave credit[i] at CREDITS and set credit_error. credit_error stays set until reset.
REQ-013 In-flight tracking: each fire enters {valid, index} into a READ_LATENCY-deep shift pipeline. The pipeline advances every cycle unconditionally; there is no back-pressure after fire.
REQ-014 Result delivery: when a pipeline entry exits, resp_valid[index]=1 for exactly that cycle, and resp_bits=vrfReadResult in the same cycle. At all other times resp_valid=0.
REQ-015 Throughput: back-to-back fires are accepted every cycle, and results return in fire order.
REQ-016 idle=1 iff no pipeline stage holds a valid entry.
REQ-017 A requester with zero credits is skipped by the round-robin search, even when req_valid is high. It becomes eligible again in the cycle after its credit_return is registered.
REQ-018 Credit counters are ceil(log2(CREDITS+1)) bits wide and never wrap below 0. A fire is impossible at 0 credits because of REQ-006.

Reset
REQ-019 While reset=1 at a clock edge:
- ptr <= 0 and every credit[i] <= CREDITS.
- All pipeline valids <= 0 and credit_error <= 0.
REQ-020 After reset: resp_valid=0, idle=1, and vrfReadRequest_valid follows REQ-008.
REQ-021 Reads in flight when reset asserts are discarded; their results are never delivered.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Round-robin: NREQ=4, all req_valid=1, vrfReadRequest_ready=1 for 8 cycles -> readSource sequence 0,1,2,3,0,1,2,3.
- Latency and routing: a single fire from requester 2 at cycle t with READ_LATENCY=2, vrfReadResult=0xDEADBEEF at t+2 -> resp_valid=4'b0100 and resp_bits=0xDEADBEEF at t+2 only; idle=0 during t+1 and t+2.
- Credit exhaustion: requester 1 alone, no returns -> exactly 4 fires, then vrfReadRequest_valid=0. One credit_return[1] pulse -> exactly one further fire, starting the following cycle.
- Port stall: vrfReadRequest_ready=0 for 5 cycles with requesters 0 and 3 valid -> grant held on 0, req_ready=0, and credits and ptr unchanged.
- Simultaneous fire and return on requester 0 at credit 4 -> credit stays 4 and credit_error stays 0. An extra return at credit 4 -> credit_error=1, held until reset.
- Reset mid-flight: reset asserted one cycle after a fire -> no resp_valid pulse afterwards, credits=4, ptr=0, idle=1.
